// File: rtl/ahb_slave_if_pkg.sv
// rtl/ahb_slave_if_pkg.sv - shared bridge constants: transfer types, phase states, region map
package ahb_slave_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DATA_WR = 2'b01,
        ST_DATA_RD = 2'b10
    } phase_state_t;

    localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
    localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
    localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
    localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_REGION0 = 3'b001;
    localparam logic [2:0] SEL_REGION1 = 3'b010;
    localparam logic [2:0] SEL_REGION2 = 3'b100;

    localparam logic [3:0] BEAT_MAX = 4'd15;

endpackage

// File: rtl/ahb_slave_if_if.sv
// rtl/ahb_slave_if_if.sv - AHB-side bus bundle for the bridge slave interface
interface ahb_slave_if_if;

    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;

    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic        wr_data_phase;
    logic [3:0]  beat_cnt;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, wr_data_phase, beat_cnt, Hrdata, Hresp
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
        input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg,
               tempselx, wr_data_phase, beat_cnt, Hrdata, Hresp
    );

endinterface

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end of the AHB-to-APB bridge
module ahb_slave_if
    import ahb_slave_if_pkg::*;
(
    input  logic         Hclk,
    input  logic         Hresetn,
    ahb_slave_if_if.slave bus
);

    logic [2:0]   w_tempselx;
    logic         w_in_range;
    logic         w_active_trans;
    logic         w_valid;
    phase_state_t r_state;
    phase_state_t w_state_next;

    logic [31:0]  r_haddr1;
    logic [31:0]  r_haddr2;
    logic [31:0]  r_hwdata1;
    logic [31:0]  r_hwdata2;
    logic         r_hwritereg;
    logic [3:0]   r_beat_cnt;

    // Inline region decoder; anything outside the three windows selects nothing.
    always_comb begin
        w_tempselx = SEL_NONE;
        if (bus.Haddr >= REGION0_BASE && bus.Haddr <= REGION0_LIMIT)
            w_tempselx = SEL_REGION0;
        else if (bus.Haddr >= REGION1_BASE && bus.Haddr <= REGION1_LIMIT)
            w_tempselx = SEL_REGION1;
        else if (bus.Haddr >= REGION2_BASE && bus.Haddr <= REGION2_LIMIT)
            w_tempselx = SEL_REGION2;
    end

    assign w_in_range     = (w_tempselx != SEL_NONE);
    assign w_active_trans = (bus.Htrans == HTRANS_NONSEQ) || (bus.Htrans == HTRANS_SEQ);
    assign w_valid        = bus.Hreadyin && w_active_trans && w_in_range;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_haddr1    <= '0;
            r_haddr2    <= '0;
            r_hwdata1   <= '0;
            r_hwdata2   <= '0;
            r_hwritereg <= 1'b0;
        end else if (bus.Hreadyin) begin
            r_haddr1    <= bus.Haddr;
            r_haddr2    <= r_haddr1;
            r_hwdata1   <= bus.Hwdata;
            r_hwdata2   <= r_hwdata1;
            r_hwritereg <= bus.Hwrite;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.Hreadyin) begin
            if (w_valid)
                w_state_next = bus.Hwrite ? ST_DATA_WR : ST_DATA_RD;
            else
                w_state_next = ST_IDLE;
        end
    end

    // A SEQ beat counts even without a preceding NONSEQ; the counter sticks at its maximum.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_beat_cnt <= '0;
        end else if (w_valid) begin
            if (bus.Htrans == HTRANS_NONSEQ)
                r_beat_cnt <= '0;
            else if (r_beat_cnt != BEAT_MAX)
                r_beat_cnt <= r_beat_cnt + 4'd1;
        end
    end

    assign bus.valid         = w_valid;
    assign bus.tempselx      = w_tempselx;
    assign bus.Haddr1        = r_haddr1;
    assign bus.Haddr2        = r_haddr2;
    assign bus.Hwdata1       = r_hwdata1;
    assign bus.Hwdata2       = r_hwdata2;
    assign bus.Hwritereg     = r_hwritereg;
    assign bus.wr_data_phase = (r_state == ST_DATA_WR);
    assign bus.beat_cnt      = r_beat_cnt;
    assign bus.Hrdata        = bus.Prdata;
    assign bus.Hresp         = HRESP_OKAY;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - scoreboard bench for the AHB slave front end
module tb_ahb_slave_if;

    logic Hclk;
    logic Hresetn;

    ahb_slave_if_if bus();

    ahb_slave_if dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    typedef struct {
        logic        valid;
        logic [2:0]  sel;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        w;
        logic        wrph;
        logic [3:0]  beat;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference state: what each pipeline stage should hold right now.
    logic [31:0] m_a1, m_a2, m_d1, m_d2;
    logic        m_w, m_wrph;
    int          m_beat;
    logic        m_valid_now;

    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        logic [31:0] off;
        if (a < 32'h8000_0000 || a > 32'h8BFF_FFFF) return 3'b000;
        off = (a - 32'h8000_0000) >> 26;
        return 3'b001 << off;
    endfunction

    task automatic model_reset();
        m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0;
        m_w = 0; m_wrph = 0; m_beat = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        logic [2:0] s;
        s = ref_sel(bus.Haddr);
        m_valid_now = bus.Hreadyin && bus.Htrans[1] && (s != 3'b000);
        e.valid = m_valid_now;
        e.sel   = s;
        e.a1    = m_a1;
        e.a2    = m_a2;
        e.d1    = m_d1;
        e.d2    = m_d2;
        e.w     = m_w;
        e.wrph  = m_wrph;
        e.beat  = 4'(m_beat);
        e.rdata = bus.Prdata;
        e.resp  = 2'b00;
        exp_q.push_back(e);
    endtask

    task automatic model_edge();
        if (!Hresetn) return;
        if (m_valid_now) begin
            if (bus.Htrans == 2'b10) m_beat = 0;
            else if (m_beat < 15)    m_beat = m_beat + 1;
        end
        if (bus.Hreadyin) begin
            m_a2   = m_a1;
            m_a1   = bus.Haddr;
            m_d2   = m_d1;
            m_d1   = bus.Hwdata;
            m_w    = bus.Hwrite;
            m_wrph = m_valid_now && bus.Hwrite;
        end
    endtask

    task automatic cycle(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [31:0] wd, input logic [31:0] pr);
        bus.Hreadyin = rdy;
        bus.Htrans   = tr;
        bus.Haddr    = a;
        bus.Hwrite   = wr;
        bus.Hwdata   = wd;
        bus.Prdata   = pr;
        push_expected();
        @(posedge Hclk);
        model_edge();
        #1;
    endtask

    // Reset is dropped between clock edges so the monitor sees its effect before any edge.
    task automatic reset_mid(input logic [1:0] tr, input logic [31:0] a, input logic wr);
        bus.Hreadyin = 1'b1;
        bus.Htrans   = tr;
        bus.Haddr    = a;
        bus.Hwrite   = wr;
        bus.Hwdata   = $urandom;
        bus.Prdata   = $urandom;
        #2;
        Hresetn = 1'b0;
        model_reset();
        push_expected();
        @(posedge Hclk);
        model_edge();
        #1;
        Hresetn = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge Hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid",         32'(bus.valid),         32'(e.valid));
                check("tempselx",      32'(bus.tempselx),      32'(e.sel));
                check("Haddr1",        bus.Haddr1,             e.a1);
                check("Haddr2",        bus.Haddr2,             e.a2);
                check("Hwdata1",       bus.Hwdata1,            e.d1);
                check("Hwdata2",       bus.Hwdata2,            e.d2);
                check("Hwritereg",     32'(bus.Hwritereg),     32'(e.w));
                check("wr_data_phase", 32'(bus.wr_data_phase), 32'(e.wrph));
                check("beat_cnt",      32'(bus.beat_cnt),      32'(e.beat));
                check("Hrdata",        bus.Hrdata,             e.rdata);
                check("Hresp",         32'(bus.Hresp),         32'(e.resp));
            end
        end
    end

    logic [31:0] bnd [8];

    initial begin
        int r;
        logic [1:0]  tr;
        logic [31:0] a;
        bnd[0] = 32'h83FF_FFFF; bnd[1] = 32'h8400_0000; bnd[2] = 32'h8C00_0000;
        bnd[3] = 32'h7FFF_FFFF; bnd[4] = 32'h8000_0000; bnd[5] = 32'h8BFF_FFFF;
        bnd[6] = 32'h87FF_FFFF; bnd[7] = 32'h8800_0000;

        Hresetn      = 1'b0;
        bus.Hreadyin = 1'b1;
        bus.Htrans   = 2'b00;
        bus.Haddr    = 32'h0;
        bus.Hwrite   = 1'b0;
        bus.Hwdata   = 32'h0;
        bus.Prdata   = 32'h0;
        model_reset();
        m_valid_now = 1'b0;
        @(posedge Hclk);
        #1;
        // Reset state, with live inputs showing combinational paths stay active.
        cycle(1, 2'b10, 32'h8000_0001, 1, 32'h11, 32'h1234_5678);
        cycle(1, 2'b10, 32'h8400_0000, 0, 32'h22, 32'h0);
        Hresetn = 1'b1;

        // Single write followed by its data phase.
        cycle(1, 2'b10, 32'h8000_0001, 1, 32'h0,  32'h0);
        cycle(1, 2'b00, 32'h0,         0, 32'h80, 32'h0);
        cycle(1, 2'b00, 32'h0,         0, 32'h0,  32'h0);

        // Four-beat write burst, stalled three cycles, then resumed.
        cycle(1, 2'b10, 32'h8000_0001, 1, 32'hA0, 32'h0);
        cycle(1, 2'b11, 32'h8000_0002, 1, 32'hA1, 32'h0);
        cycle(1, 2'b11, 32'h8000_0003, 1, 32'hA2, 32'h0);
        cycle(1, 2'b11, 32'h8000_0004, 1, 32'hA3, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 2'b11, 32'h8000_0005, 1, 32'hEE, 32'h0);
        cycle(1, 2'b11, 32'h8000_0005, 1, 32'hA4, 32'h0);
        cycle(1, 2'b01, 32'h8000_0006, 1, 32'hA5, 32'h0);
        cycle(1, 2'b00, 32'h0,         0, 32'h0,  32'h0);

        // Decode boundaries.
        for (int i = 0; i < 8; i++) cycle(1, 2'b10, bnd[i], 0, $urandom, $urandom);

        // Read with pass-through data.
        cycle(1, 2'b10, 32'h8800_0010, 0, 32'h0, 32'hA5A5_0001);
        cycle(1, 2'b00, 32'h0,         0, 32'h0, 32'hA5A5_0001);

        // Orphan SEQ, then a long SEQ run to reach saturation.
        cycle(1, 2'b11, 32'h8000_0010, 1, 32'h5, 32'h0);
        cycle(1, 2'b10, 32'h8400_0000, 1, 32'h6, 32'h0);
        for (int i = 0; i < 18; i++) cycle(1, 2'b11, 32'h8400_0004 + 32'(i*4), 1, $urandom, 32'h0);
        cycle(1, 2'b11, 32'h9000_0000, 1, 32'h7, 32'h0);

        // Reset arriving at beat 2 of a burst, then a fresh transfer.
        cycle(1, 2'b10, 32'h8000_0001, 1, 32'hB0, 32'h0);
        cycle(1, 2'b11, 32'h8000_0002, 1, 32'hB1, 32'h0);
        reset_mid(2'b11, 32'h8000_0003, 1);
        cycle(1, 2'b11, 32'h8000_0004, 0, 32'hB3, 32'h0);
        cycle(1, 2'b10, 32'h8800_0000, 0, 32'hB4, 32'h0);
        cycle(1, 2'b00, 32'h0,         0, 32'h0,  32'h0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom % 10;
            tr = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
            r = $urandom % 4;
            if (r == 0)      a = $urandom;
            else if (r == 3) a = bnd[$urandom % 8];
            else             a = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
            if (($urandom % 60) == 0) reset_mid(tr, a, 1'($urandom));
            else cycle(1'(($urandom % 5) != 0), tr, a, 1'($urandom), $urandom, $urandom);
        end

        repeat (3) @(negedge Hclk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
